// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for rv_cpu: shares one memory port between instruction
// fetch and load/store, one transaction in flight, data-priority with a fetch starvation bound.
module mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req_valid,
    input  logic [31:0] if_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    input  logic        d_req_valid,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both
    // high; the requester holds valid and its fields stable until it sees ready.

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_q;
    logic          owner_q;
    logic [31:0]   addr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q;
    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          fetch_wins;
    logic          data_wins;

    // Data has priority unless fetch has already waited through a full streak.
    always_comb begin
        fetch_wins = 1'b0;
        data_wins  = 1'b0;
        streak_d   = streak_q;
        if (state_q == S_IDLE) begin
            if (d_req_valid && !(if_req_valid && streak_q == STREAK_MAX)) begin
                data_wins = 1'b1;
            end else if (if_req_valid) begin
                fetch_wins = 1'b1;
            end
        end
        if (fetch_wins) begin
            streak_d = '0;
        end else if (data_wins) begin
            if (!if_req_valid) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            streak_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_wins || data_wins) begin
                        state_q  <= S_ISSUE;
                        owner_q  <= data_wins;
                        addr_q   <= data_wins ? d_addr : if_addr;
                        we_q     <= data_wins & d_we;
                        wdata_q  <= data_wins ? d_wdata : '0;
                        wstrb_q  <= data_wins ? d_wstrb : '0;
                        streak_q <= streak_d;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= mem_resp_data;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_req_ready  = fetch_wins;
    assign d_req_ready   = data_wins;
    assign mem_req_valid = (state_q == S_ISSUE);
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign if_resp_valid = (state_q == S_RESP) && !owner_q;
    assign d_resp_valid  = (state_q == S_RESP) && owner_q;
    assign if_resp_data  = rdata_q;
    assign d_resp_data   = rdata_q;
    assign busy          = (state_q != S_IDLE);
    assign dbg_state_o   = state_q;

endmodule
